audio_soft_mute: RTL

//  Click-free mute/unmute stage between the tsconf core's SOUND_L/SOUND_R outputs and the i2s serializer.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_gain_ch.sv | 95 +++++++++
 rtl/audio_soft_mute.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio soft-mute stage.
package audio_pkg;

    typedef enum logic [2:0] {MUTED, HOLD, RAMP_UP, UNMUTED, RAMP_DOWN} mute_state_t;

    localparam int              GAIN_W   = 9;
    localparam logic [GAIN_W-1:0] GAIN_ONE = 9'd256;

    // Width of a down-counter that must hold n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_gain_ch.sv
// One audio channel: optional DC blocker (AUDIO_DCBLOCK_EN), gain multiply, output register.
module audio_gain_ch
    import audio_pkg::*;
#(
    parameter int DW = 16
`ifdef AUDIO_DCBLOCK_EN
    , parameter int DC_SHIFT = 10
`endif
) (
    input  logic              clk_sys,
    input  logic              reset_n,
`ifdef AUDIO_DCBLOCK_EN
    input  logic              ce,
    input  logic              clr,
`endif
    input  logic [DW-1:0]     in_x,
    input  logic [GAIN_W-1:0] gain,
    output logic [DW-1:0]     out_y
);

    logic [DW-1:0] mult_in;

`ifdef AUDIO_DCBLOCK_EN
    localparam int XW = DW + 2;

    localparam logic signed [XW+1:0] DMAX = {{5{1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW+1:0] DMIN = {{5{1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [XW+1:0] YMAX = {{3{1'b0}}, {(XW-1){1'b1}}};
    localparam logic signed [XW+1:0] YMIN = {{3{1'b1}}, {(XW-1){1'b0}}};

    logic signed [XW-1:0] x1_q, x1_d, y1_q, y1_d;
    logic        [DW-1:0] filt_q, filt_d;
    logic signed [XW+1:0] y_full;
    logic signed [XW-1:0] y1_shr;

    // y = x - x1 + y1 - (y1 >>> DC_SHIFT), evaluated with two guard bits.
    always_comb begin
        y1_shr = y1_q >>> DC_SHIFT;
        y_full = $signed({{4{in_x[DW-1]}}, in_x})
               - $signed({{2{x1_q[XW-1]}}, x1_q})
               + $signed({{2{y1_q[XW-1]}}, y1_q})
               - $signed({{2{y1_shr[XW-1]}}, y1_shr});

        if (y_full > DMAX)      filt_d = DMAX[DW-1:0];
        else if (y_full < DMIN) filt_d = DMIN[DW-1:0];
        else                    filt_d = y_full[DW-1:0];

        x1_d = x1_q;
        y1_d = y1_q;
        if (clr) begin
            x1_d = '0;
            y1_d = '0;
        end else if (ce) begin
            x1_d = $signed({{2{in_x[DW-1]}}, in_x});
            if (y_full > YMAX)      y1_d = YMAX[XW-1:0];
            else if (y_full < YMIN) y1_d = YMIN[XW-1:0];
            else                    y1_d = y_full[XW-1:0];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            x1_q   <= '0;
            y1_q   <= '0;
            filt_q <= '0;
        end else begin
            x1_q   <= x1_d;
            y1_q   <= y1_d;
            filt_q <= filt_d;
        end
    end

    assign mult_in = filt_q;
`else
    assign mult_in = in_x;
`endif

    logic signed [DW+8:0] prod;
    logic        [DW-1:0] out_d, out_q;

    // Taking bits [DW+7:8] of the signed product is the arithmetic >>> 8 (floor).
    always_comb begin
        prod  = $signed({{9{mult_in[DW-1]}}, mult_in}) * $signed({{DW{1'b0}}, gain});
        out_d = prod[DW+7:8];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) out_q <= '0;
        else          out_q <= out_d;
    end

    assign out_y = out_q;

endmodule

// File: rtl/audio_soft_mute.sv
// Click-free mute/unmute: hold after reset, then linear gain ramp 0..256 paced by ce.
// Optional DC blocker per channel when AUDIO_DCBLOCK_EN is defined.
module audio_soft_mute
    import audio_pkg::*;
#(
    parameter int DW         = 16,
    parameter int HOLD_TICKS = 2**20,
    parameter int RAMP_DIV   = 1024,
    parameter int DC_SHIFT   = 10
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          mute,
    input  logic [DW-1:0] in_l,
    input  logic [DW-1:0] in_r,
    output logic [DW-1:0] out_l,
    output logic [DW-1:0] out_r,
    output logic          muted,
    output logic          ramping
);

    if (HOLD_TICKS < 1 || RAMP_DIV < 1 || DC_SHIFT < 1 || DC_SHIFT >= DW) begin : g_param_check
        $error("audio_soft_mute: illegal parameter value");
    end

    localparam int HW = cnt_width(HOLD_TICKS);
    localparam int SW = cnt_width(RAMP_DIV);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);
    localparam logic [SW-1:0] STEP_LOAD = SW'(RAMP_DIV - 1);

    mute_state_t       state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [SW-1:0]     step_q, step_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              muted_q, muted_d;
    logic              ramping_q, ramping_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        step_d    = step_q;
        gain_d    = gain_q;
        muted_d   = (gain_q == '0);
        ramping_d = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

        case (state_q)
            MUTED: begin
                gain_d = '0;
                if (!mute) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (mute) begin
                    state_d = MUTED;
                end else if (ce) begin
                    if (hold_q == '0) begin
                        state_d = RAMP_UP;
                        step_d  = STEP_LOAD;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            // A direction change takes priority over a step landing on the same cycle.
            RAMP_UP: begin
                if (mute) begin
                    state_d = RAMP_DOWN;
                    step_d  = STEP_LOAD;
                end else if (ce) begin
                    if (step_q == '0) begin
                        gain_d = gain_q + 1'b1;
                        step_d = STEP_LOAD;
                        if (gain_q == (GAIN_ONE - 9'd1)) state_d = UNMUTED;
                    end else begin
                        step_d = step_q - 1'b1;
                    end
                end
            end
            UNMUTED: begin
                gain_d = GAIN_ONE;
                if (mute) begin
                    state_d = RAMP_DOWN;
                    step_d  = STEP_LOAD;
                end
            end
            RAMP_DOWN: begin
                if (!mute) begin
                    state_d = RAMP_UP;
                    step_d  = STEP_LOAD;
                end else if (ce) begin
                    if (step_q == '0) begin
                        gain_d = gain_q - 1'b1;
                        step_d = STEP_LOAD;
                        if (gain_q == 9'd1) state_d = MUTED;
                    end else begin
                        step_d = step_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = MUTED;
                gain_d  = '0;
            end
        endcase
    end

    // NOTE: only control/state flops get the async reset; nothing here is a memory array.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= MUTED;
            hold_q    <= '0;
            step_q    <= '0;
            gain_q    <= '0;
            muted_q   <= 1'b1;
            ramping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            step_q    <= step_d;
            gain_q    <= gain_d;
            muted_q   <= muted_d;
            ramping_q <= ramping_d;
        end
    end

    gain_range_a: assert property (@(posedge clk_sys) disable iff (!reset_n) gain_q <= GAIN_ONE);

    assign muted   = muted_q;
    assign ramping = ramping_q;

`ifdef AUDIO_DCBLOCK_EN
    audio_gain_ch #(.DW(DW), .DC_SHIFT(DC_SHIFT)) u_ch_l (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .clr(state_q == MUTED),
        .in_x(in_l), .gain(gain_q), .out_y(out_l)
    );
    audio_gain_ch #(.DW(DW), .DC_SHIFT(DC_SHIFT)) u_ch_r (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .clr(state_q == MUTED),
        .in_x(in_r), .gain(gain_q), .out_y(out_r)
    );
`else
    audio_gain_ch #(.DW(DW)) u_ch_l (
        .clk_sys(clk_sys), .reset_n(reset_n), .in_x(in_l), .gain(gain_q), .out_y(out_l)
    );
    audio_gain_ch #(.DW(DW)) u_ch_r (
        .clk_sys(clk_sys), .reset_n(reset_n), .in_x(in_r), .gain(gain_q), .out_y(out_r)
    );
`endif

endmodule
